pito_irq_ctrl: RTL
==================

Name: pito_irq_ctrl

Overview:
- Per-hart machine-mode interrupt controller for the 8-hart PITO barrel core.
- Latches interrupt sources per hart: external, software (MSIP), timer and MVU completion.
- Each cycle, evaluates the hart the barrel is about to issue and raises a registered trap request with a priority-resolved mcause.
- Sits between the MVU array / SoC interrupt lines and the core's CSR/trap logic; owns the MIP state and a per-hart in-trap guard.

Parameters:
- NUM_HARTS, 8, number of barrel harts. HART_W = $clog2(NUM_HARTS).
- XLEN, 32, CSR data width.
- TIMECMP_CSR, 12'h7C0, CSR address of the per-hart mtimecmp register. Used only with the optional feature.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- fetch_hart_i  in  HART_W  hart entering issue this cycle
- ext_irq_i  in  NUM_HARTS  level external interrupt, one per hart
- mvu_irq_i  in  NUM_HARTS  one-cycle MVU-done pulse, one per hart
- mie_i  in  NUM_HARTS*XLEN  per-hart MIE CSR contents, from the CSR file
- mstatus_mie_i  in  NUM_HARTS  per-hart mstatus.MIE
- csr_we_i  in  1  CSR write strobe
- csr_op_i  in  3  001 write, 010 set, 011 clear; other codes ignored
- csr_hart_i  in  HART_W  hart for the CSR write or read
- csr_addr_i  in  12  CSR address
- csr_wdata_i  in  XLEN  CSR write operand
- mip_rdata_o  out  XLEN  combinational MIP value of csr_hart_i
- irq_req_o  out  1  trap request, registered
- irq_hart_o  out  HART_W  hart the request targets
- irq_cause_o  out  XLEN  mcause value
- irq_ack_i  in  1  core committed the trap for irq_hart_o
- mret_i  in  1  hart mret_hart_i executed MRET
- mret_hart_i  in  HART_W  hart executing MRET

Behaviour:
- Reset (rst_n=0 at a clk edge): all state clears.
  - mvu_pend, msip and in_trap cleared for all harts.
  - irq_req_o=0, irq_hart_o=0, irq_cause_o=0.
  - Reset mid-request drops the request on the next edge.
- Per-hart MIP bits:
  - bit11 MEIP = ext_irq_i[h], level, not stored.
  - bit3 MSIP = msip[h] register.
  - bit7 MTIP, timer (see the optional feature).
  - bit16 MVIP = mvu_pend[h].
  - All other bits read 0.
- CSR writes:
  - Only csr_addr_i=12'h344 with a valid op modifies state, and only bit3 (MSIP) is writable.
  - Write: msip=wdata[3]. Set: msip|=wdata[3]. Clear: msip&=~wdata[3].
  - Writes to other MIP bits are silently discarded.
- MVU pending:
  - mvu_pend[h] sets on mvu_irq_i[h].
  - It clears on irq_ack_i when irq_hart_o==h and the cause was MVU.
  - Set and clear in the same cycle: set wins.
- Eligibility for hart h: mstatus_mie_i[h]=1 AND in_trap[h]=0 AND (MIP[h] & mie_i[h]) != 0.
- Priority: MEI > MSI > MTI > MVU. irq_cause_o = {1'b1, code} with code 11, 3, 7 or 16 respectively.
- Pipeline, 1-cycle latency:
  - At edge t+1, irq_req_o takes the eligibility of fetch_hart_i sampled at t.
  - irq_hart_o and irq_cause_o register together with it.
  - The request holds for one cycle only; the next edge re-evaluates for the new fetch hart.
- Ack handshake:
  - irq_ack_i is valid only in a cycle where irq_req_o=1.
  - Ack sets in_trap[irq_hart_o] and clears that hart's MVU pending if the cause was MVU.
  - irq_ack_i while irq_req_o=0 is ignored.
  - If the hart is re-evaluated in the same cycle as its ack, the new in_trap value is used, so no duplicate request is raised.
- MRET: mret_i clears in_trap[mret_hart_i].
  - mret_i and ack for the same hart in the same cycle: ack wins, in_trap=1.
- Un-acked request: the request is dropped. The source stays pending and is re-requested on the hart's next barrel slot (NUM_HARTS cycles later).
- mip_rdata_o is combinational. During a same-cycle write it reflects the pre-write value.

Optional Feature:
- Macro: PITO_IRQ_TIMER_EN.
- Defined:
  - Free-running 32-bit mtime counter; reset 0, +1 per cycle, wraps at 2^32-1 to 0.
  - Per-hart mtimecmp register, reset 32'hFFFFFFFF.
  - A CSR write to TIMECMP_CSR loads mtimecmp[csr_hart_i] using the same write/set/clear ops.
  - MTIP[h] = (mtime >= mtimecmp[h]), unsigned, registered one cycle.
- Undefined: MTIP is tied to 0, there is no counter or compare storage, and writes to TIMECMP_CSR are ignored.

Test Plan:
- Reset, then mstatus_mie=all 1, mie[2]=1<<16.
  - Pulse mvu_irq_i[2] and step fetch_hart_i 0..7.
  - Expect irq_req_o=1 exactly one cycle after fetch_hart_i=2, with irq_hart_o=2 and irq_cause_o=32'h80000010.
  - Ack, then expect no further requests for hart 2.
- Hart 5 with mie=all 1, ext_irq_i[5]=1, MSIP set via csr_op=010 and wdata=8, MVU pending.
  - Expect cause 32'h8000000B.
  - Drop ext_irq_i, expect 32'h80000003 on hart 5's next slot.
  - Clear MSIP (op 011), expect 32'h80000010.
- Pulse mvu_irq_i[0] in the same cycle as an MVU ack for hart 0.
  - Expect mvu_pend[0] to remain set and mip_rdata_o bit16=1.
- After an ack on hart 3, hold the source pending.
  - Expect no request while in_trap[3]=1.
  - Pulse mret_i with mret_hart_i=3, expect a request on the next hart-3 slot.
- Hart 1 eligible with mstatus_mie_i[1]=0: expect no request.
  - Also write wdata=32'hFFFFFFFF to MIP: expect mip_rdata_o shows only bit3 added.
- With PITO_IRQ_TIMER_EN: write mtimecmp[4]=20 and mie[4]=1<<7.
  - Expect MTIP[4]=1 from mtime=20 onward and cause 32'h80000007.
  - Without the macro: mip_rdata_o bit7=0 always.

Source files
------------

// File: rtl/pito_irq_ctrl.sv
// pito_irq_ctrl: per-hart machine-mode interrupt controller for the 8-hart PITO barrel core.
// Define PITO_IRQ_TIMER_EN to add the mtime counter and per-hart mtimecmp timer source (MTIP).
module pito_irq_ctrl #(
    parameter int unsigned NUM_HARTS   = 8,
    parameter int unsigned XLEN        = 32,
    parameter logic [11:0] TIMECMP_CSR = 12'h7C0,
    localparam int unsigned HART_W     = $clog2(NUM_HARTS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [HART_W-1:0]         fetch_hart_i,
    input  logic [NUM_HARTS-1:0]      ext_irq_i,
    input  logic [NUM_HARTS-1:0]      mvu_irq_i,
    input  logic [NUM_HARTS*XLEN-1:0] mie_i,
    input  logic [NUM_HARTS-1:0]      mstatus_mie_i,
    input  logic                      csr_we_i,
    input  logic [2:0]                csr_op_i,
    input  logic [HART_W-1:0]         csr_hart_i,
    input  logic [11:0]               csr_addr_i,
    input  logic [XLEN-1:0]           csr_wdata_i,
    output logic [XLEN-1:0]           mip_rdata_o,
    output logic                      irq_req_o,
    output logic [HART_W-1:0]         irq_hart_o,
    output logic [XLEN-1:0]           irq_cause_o,
    input  logic                      irq_ack_i,
    input  logic                      mret_i,
    input  logic [HART_W-1:0]         mret_hart_i
);

    localparam logic [11:0]     MIP_CSR   = 12'h344;
    localparam int unsigned     MSI_BIT   = 3;
    localparam int unsigned     MTI_BIT   = 7;
    localparam int unsigned     MEI_BIT   = 11;
    localparam int unsigned     MVU_BIT   = 16;
    localparam logic [XLEN-1:0] MVU_CAUSE = {1'b1, (XLEN-1)'(MVU_BIT)};

    logic [NUM_HARTS-1:0]           msip, mvu_pend, in_trap, mtip;
    logic [NUM_HARTS-1:0]           msip_nxt, mvu_pend_nxt, in_trap_nxt;
    logic [NUM_HARTS-1:0][XLEN-1:0] mip, mie;
    logic [XLEN-1:0]                pend_c, cause_c;
    logic                           ack_c, elig_c, mip_we_c;

    assign mie = mie_i;

    // MEIP is the live level; the other sources come from local state.
    for (genvar g = 0; g < NUM_HARTS; g++) begin : g_mip
        assign mip[g] = (XLEN'(ext_irq_i[g]) << MEI_BIT)
                      | (XLEN'(msip[g])      << MSI_BIT)
                      | (XLEN'(mtip[g])      << MTI_BIT)
                      | (XLEN'(mvu_pend[g])  << MVU_BIT);
    end

    assign mip_rdata_o = mip[csr_hart_i];
    assign ack_c       = irq_ack_i && irq_req_o;
    assign mip_we_c    = csr_we_i && (csr_addr_i == MIP_CSR);

    // Next-state for MSIP, MVU pending and the in-trap guard.
    always_comb begin
        msip_nxt     = msip;
        mvu_pend_nxt = mvu_pend;
        in_trap_nxt  = in_trap;
        if (mip_we_c) begin
            case (csr_op_i)
                3'b001:  msip_nxt[csr_hart_i] = csr_wdata_i[MSI_BIT];
                3'b010:  msip_nxt[csr_hart_i] = msip[csr_hart_i] | csr_wdata_i[MSI_BIT];
                3'b011:  msip_nxt[csr_hart_i] = msip[csr_hart_i] & ~csr_wdata_i[MSI_BIT];
                default: ;
            endcase
        end
        if (mret_i) begin
            in_trap_nxt[mret_hart_i] = 1'b0;
        end
        // Ack overrides a same-cycle MRET on the same hart.
        if (ack_c) begin
            in_trap_nxt[irq_hart_o] = 1'b1;
            if (irq_cause_o == MVU_CAUSE) begin
                mvu_pend_nxt[irq_hart_o] = 1'b0;
            end
        end
        mvu_pend_nxt = mvu_pend_nxt | mvu_irq_i;
    end

    // Evaluate the issuing hart against the post-ack guard so an acked hart is not re-requested.
    always_comb begin
        pend_c  = mip[fetch_hart_i] & mie[fetch_hart_i];
        elig_c  = mstatus_mie_i[fetch_hart_i] && !in_trap_nxt[fetch_hart_i] && (pend_c != '0);
        cause_c = '0;
        if (pend_c[MEI_BIT]) begin
            cause_c = {1'b1, (XLEN-1)'(MEI_BIT)};
        end else if (pend_c[MSI_BIT]) begin
            cause_c = {1'b1, (XLEN-1)'(MSI_BIT)};
        end else if (pend_c[MTI_BIT]) begin
            cause_c = {1'b1, (XLEN-1)'(MTI_BIT)};
        end else if (pend_c[MVU_BIT]) begin
            cause_c = MVU_CAUSE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            msip        <= '0;
            mvu_pend    <= '0;
            in_trap     <= '0;
            irq_req_o   <= 1'b0;
            irq_hart_o  <= '0;
            irq_cause_o <= '0;
        end else begin
            msip        <= msip_nxt;
            mvu_pend    <= mvu_pend_nxt;
            in_trap     <= in_trap_nxt;
            irq_req_o   <= elig_c;
            irq_hart_o  <= fetch_hart_i;
            irq_cause_o <= elig_c ? cause_c : '0;
        end
    end

`ifdef PITO_IRQ_TIMER_EN
    logic [31:0]                 mtime;
    logic [NUM_HARTS-1:0][31:0]  mtimecmp;
    logic                        tcmp_we_c;

    function automatic logic [31:0] csr_apply(input logic [31:0] old, input logic [2:0] op,
                                              input logic [31:0] wdata);
        case (op)
            3'b001:  return wdata;
            3'b010:  return old | wdata;
            3'b011:  return old & ~wdata;
            default: return old;
        endcase
    endfunction

    assign tcmp_we_c = csr_we_i && (csr_addr_i == TIMECMP_CSR);

    // Free-running mtime; MTIP is the registered unsigned compare.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mtime    <= '0;
            mtimecmp <= '1;
            mtip     <= '0;
        end else begin
            mtime <= mtime + 32'd1;
            for (int h = 0; h < NUM_HARTS; h++) begin
                mtip[h] <= (mtime >= mtimecmp[h]);
            end
            if (tcmp_we_c) begin
                mtimecmp[csr_hart_i] <= csr_apply(mtimecmp[csr_hart_i], csr_op_i, 32'(csr_wdata_i));
            end
        end
    end
`else
    logic unused_cfg;

    assign mtip       = '0;
    assign unused_cfg = ^{TIMECMP_CSR, csr_wdata_i[XLEN-1:MSI_BIT+1], csr_wdata_i[MSI_BIT-1:0]};
`endif

endmodule
